// File: rtl/downstream_cancel_tracker.sv
// Per-client cancelled-quantity table fed by exchange cancel/clear messages.
// Each message is handled as a read-modify-write over IDLE -> LOOKUP -> WRITE.
module downstream_cancel_tracker (
    input  logic        clk,
    input  logic        HRESETn,
    input  logic        msg_valid,
    output logic        msg_ready,
    input  logic [4:0]  msg_client_id,
    input  logic [15:0] msg_amount,
    input  logic        msg_clear,
    input  logic [4:0]  rd_client_id,
    output logic [15:0] cancelled_orders,
    output logic        upd_valid,
    output logic [4:0]  upd_client_id,
    output logic [15:0] upd_value,
    output logic        saturated,
    output logic        busy
);

    localparam int unsigned ID_W  = 5;
    localparam int unsigned VAL_W = 16;
    localparam int unsigned DEPTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        WRITE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [VAL_W-1:0]   amt_q, amt_d;
    logic               clr_q, clr_d;
    logic [VAL_W-1:0]   work_q, work_d;
    logic               upd_valid_q, upd_valid_d;
    logic [ID_W-1:0]    upd_id_q, upd_id_d;
    logic [VAL_W-1:0]   upd_val_q, upd_val_d;
    logic               sat_q, sat_d;
    logic               ready_q, busy_q;
    logic [VAL_W-1:0]   rd_q;
    logic [VAL_W-1:0]   table_q [DEPTH];

    logic               wr_en_c;
    logic [VAL_W:0]     sum_c;
    logic [VAL_W-1:0]   new_val_c;

    // Saturating add of the looked-up total and the captured amount
    always_comb begin
        sum_c     = {1'b0, work_q} + {1'b0, amt_q};
        new_val_c = '0;
        if (!clr_q) begin
            new_val_c = sum_c[VAL_W] ? {VAL_W{1'b1}} : sum_c[VAL_W-1:0];
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        amt_d       = amt_q;
        clr_d       = clr_q;
        work_d      = work_q;
        upd_valid_d = 1'b0;
        upd_id_d    = upd_id_q;
        upd_val_d   = upd_val_q;
        sat_d       = sat_q;
        wr_en_c     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (msg_valid) begin
                    id_d    = msg_client_id;
                    amt_d   = msg_amount;
                    clr_d   = msg_clear;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                work_d  = table_q[id_q];
                state_d = WRITE;
            end
            WRITE: begin
                wr_en_c     = 1'b1;
                upd_valid_d = 1'b1;
                upd_id_d    = id_q;
                upd_val_d   = new_val_c;
                if (!clr_q && sum_c[VAL_W]) begin
                    sat_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Read port samples the table before this edge's write lands
    always_ff @(posedge clk) begin
        if (!HRESETn) begin
            state_q     <= IDLE;
            id_q        <= '0;
            amt_q       <= '0;
            clr_q       <= 1'b0;
            work_q      <= '0;
            upd_valid_q <= 1'b0;
            upd_id_q    <= '0;
            upd_val_q   <= '0;
            sat_q       <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            rd_q        <= '0;
            table_q     <= '{default: '0};
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            amt_q       <= amt_d;
            clr_q       <= clr_d;
            work_q      <= work_d;
            upd_valid_q <= upd_valid_d;
            upd_id_q    <= upd_id_d;
            upd_val_q   <= upd_val_d;
            sat_q       <= sat_d;
            ready_q     <= (state_d == IDLE);
            busy_q      <= (state_d != IDLE);
            rd_q        <= table_q[rd_client_id];
            if (wr_en_c) begin
                table_q[id_q] <= new_val_c;
            end
        end
    end

    assign msg_ready        = ready_q;
    assign busy             = busy_q;
    assign cancelled_orders = rd_q;
    assign upd_valid        = upd_valid_q;
    assign upd_client_id    = upd_id_q;
    assign upd_value        = upd_val_q;
    assign saturated        = sat_q;

endmodule

// File: tb/tb_downstream_cancel_tracker.sv
// Scoreboard bench for downstream_cancel_tracker: the driver pushes expected
// writes from a plain array model, an independent monitor checks each upd_valid.
module tb_downstream_cancel_tracker;

    logic        clk = 1'b0;
    logic        HRESETn;
    logic        msg_valid;
    logic        msg_ready;
    logic [4:0]  msg_client_id;
    logic [15:0] msg_amount;
    logic        msg_clear;
    logic [4:0]  rd_client_id;
    logic [15:0] cancelled_orders;
    logic        upd_valid;
    logic [4:0]  upd_client_id;
    logic [15:0] upd_value;
    logic        saturated;
    logic        busy;

    always #5 clk = ~clk;

    downstream_cancel_tracker dut (
        .clk              (clk),
        .HRESETn          (HRESETn),
        .msg_valid        (msg_valid),
        .msg_ready        (msg_ready),
        .msg_client_id    (msg_client_id),
        .msg_amount       (msg_amount),
        .msg_clear        (msg_clear),
        .rd_client_id     (rd_client_id),
        .cancelled_orders (cancelled_orders),
        .upd_valid        (upd_valid),
        .upd_client_id    (upd_client_id),
        .upd_value        (upd_value),
        .saturated        (saturated),
        .busy             (busy)
    );

    typedef struct {
        int id;
        int val;
        int sat;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    int   model_tbl [32];
    int   model_sat = 0;
    exp_t sb_q [$];
    int   cyc      = 0;
    int   upd_cnt  = 0;
    int   last_acc = 0;
    bit   started  = 1'b0;
    bit   rst_edge = 1'b1;
    bit   prev_upd = 1'b0;
    bit   prev_sat = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        rst_edge <= !HRESETn;
    end

    // Monitor: scoreboard pop on every update plus continuous invariants
    always @(negedge clk) begin
        if (started) begin
            if (upd_valid) begin
                upd_cnt++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_upd_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("upd_client_id", int'(upd_client_id), e.id);
                    chk("upd_value", int'(upd_value), e.val);
                    chk("upd_saturated", int'(saturated), e.sat);
                end
            end
            if (prev_upd && upd_valid) chk("upd_valid_twice", 1, 0);
            if (busy == msg_ready) chk("busy_vs_ready", int'(busy), int'(!msg_ready));
            if (prev_sat && !saturated && !rst_edge) chk("saturated_fell", 0, 1);
        end
        prev_upd = upd_valid;
        prev_sat = saturated;
    end

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model_tbl[i] = 0;
        model_sat = 0;
        sb_q.delete();
    endtask

    task automatic reset_dut(input int n);
        HRESETn = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        HRESETn = 1'b1;
        model_reset();
    endtask

    // Present a message and hold it until accepted; leaves msg_valid high
    task automatic send(input int id, input int amt, input int clr);
        int budget;
        int nv;
        budget        = 0;
        msg_valid     = 1'b1;
        msg_client_id = 5'(id);
        msg_amount    = 16'(amt);
        msg_clear     = 1'(clr);
        while (!msg_ready && budget < 20) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (!msg_ready) begin
            chk("send_timeout", 0, 1);
        end else begin
            @(posedge clk);
            nv = (clr != 0) ? 0 : model_tbl[id] + amt;
            if (clr == 0 && nv > 65535) begin
                nv        = 65535;
                model_sat = 1;
            end
            model_tbl[id] = nv;
            sb_q.push_back('{id, nv, model_sat});
            #1;
            last_acc = cyc;
        end
    endtask

    task automatic idle();
        msg_valid = 1'b0;
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (sb_q.size() != 0 && b < 50) begin
            @(posedge clk);
            #1;
            b++;
        end
        if (sb_q.size() != 0) chk("drain_timeout", sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_rd(input int id);
        rd_client_id = 5'(id);
        @(posedge clk);
        #1;
        chk("cancelled_orders", int'(cancelled_orders), model_tbl[id]);
    endtask

    initial begin
        int accs [6];
        int ids  [6];
        int base;
        HRESETn       = 1'b0;
        msg_valid     = 1'b1;
        msg_client_id = 5'd1;
        msg_amount    = 16'd77;
        msg_clear     = 1'b0;
        rd_client_id  = '0;

        // Reset with a message pending: must not be accepted
        reset_dut(3);
        msg_valid = 1'b0;
        started   = 1'b1;
        chk("rst_msg_ready", int'(msg_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_upd_valid", int'(upd_valid), 0);
        chk("rst_upd_client_id", int'(upd_client_id), 0);
        chk("rst_upd_value", int'(upd_value), 0);
        chk("rst_saturated", int'(saturated), 0);
        chk("rst_cancelled_orders", int'(cancelled_orders), 0);
        check_rd(1);

        // Single add: update visible three cycles after acceptance
        rd_client_id = 5'd3;
        send(3, 100, 0);
        idle();
        chk("lat_busy_n1", int'(busy), 1);
        chk("lat_upd_n1", int'(upd_valid), 0);
        @(posedge clk); #1;
        chk("lat_upd_n2", int'(upd_valid), 0);
        @(posedge clk); #1;
        chk("lat_upd_n3", int'(upd_valid), 1);
        chk("lat_ready_n3", int'(msg_ready), 1);
        chk("lat_upd_id", int'(upd_client_id), 3);
        chk("lat_upd_value", int'(upd_value), 100);
        drain();
        check_rd(3);
        chk("rd3_const", int'(cancelled_orders), 100);

        // Saturation, then a clear that leaves the sticky flag alone
        send(7, 40000, 0);
        send(7, 30000, 0);
        idle();
        drain();
        chk("sat_value", int'(upd_value), 65535);
        chk("sat_flag", int'(saturated), 1);
        send(7, 0, 1);
        idle();
        drain();
        chk("clr_value", int'(upd_value), 0);
        chk("clr_sat_sticky", int'(saturated), 1);

        // Back-to-back burst with msg_valid held high
        ids  = '{1, 2, 1, 4, 2, 0};
        base = upd_cnt;
        for (int i = 0; i < 6; i++) begin
            send(ids[i], (i == 2) ? 0 : int'($urandom_range(0, 5000)), 0);
            accs[i] = last_acc;
        end
        idle();
        for (int i = 1; i < 6; i++) chk("burst_gap", accs[i] - accs[i-1], 3);
        drain();
        chk("burst_upd_count", upd_cnt - base, 6);
        check_rd(0);
        check_rd(1);
        check_rd(2);
        check_rd(4);

        // Read of an entry on the same edge it is written
        send(5, 10, 0);
        idle();
        drain();
        rd_client_id = 5'd5;
        send(5, 15, 0);
        idle();
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rw_upd_valid", int'(upd_valid), 1);
        chk("rw_pre_write", int'(cancelled_orders), 10);
        @(posedge clk); #1;
        chk("rw_post_write", int'(cancelled_orders), 25);
        drain();

        // Reset during WRITE discards the in-flight message
        send(9, 50, 0);
        idle();
        @(posedge clk); #1;
        chk("inflight_busy", int'(busy), 1);
        reset_dut(1);
        chk("inflight_upd_valid", int'(upd_valid), 0);
        chk("inflight_ready", int'(msg_ready), 1);
        chk("inflight_sat", int'(saturated), 0);
        @(posedge clk); #1;
        chk("inflight_no_pulse", int'(upd_valid), 0);
        check_rd(9);

        // Randomized traffic against the array model
        for (int i = 0; i < 48; i++) begin
            int id;
            int amt;
            int clr;
            id  = int'($urandom_range(0, 7));
            clr = ($urandom_range(0, 7) == 0) ? 1 : 0;
            amt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(30000, 65535))
                                              : int'($urandom_range(0, 2000));
            send(id, amt, clr);
            if ($urandom_range(0, 2) == 0) begin
                idle();
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
            if (i % 8 == 7) begin
                idle();
                drain();
                check_rd(int'($urandom_range(0, 7)));
            end
        end
        idle();
        drain();
        for (int i = 0; i < 8; i++) check_rd(i);
        chk("sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0t required=<200000", $time);
        $fatal(1, "timeout");
    end

endmodule
